// File: rtl/udp_ip_hdr_fill.sv
// Finalises IPv4/UDP headers: writes the total length, the UDP length and a zero UDP checksum.
// It can then read back the 20-byte IPv4 header and write the IPv4 header checksum.
module udp_ip_hdr_fill #(
  parameter int ADDR_WIDTH    = 11,
  parameter int LEN_ADJ       = 2,
  parameter int HDR_IDX_WIDTH = 6,
  parameter int IP_HDR_BASE   = 0,
  parameter int UDP_HDR_BASE  = 20,
  parameter bit CSUM_EN       = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_trig,
  input  logic [ADDR_WIDTH-1:0]    i_data_st,
  input  logic [ADDR_WIDTH-1:0]    i_next_data_st,
  output logic [HDR_IDX_WIDTH-1:0] o_hdr_idx,
  output logic [7:0]               o_hdr_byte,
  output logic                     o_wr_hdr_en,
  output logic                     o_rd_hdr_en,
  input  logic [7:0]               i_hdr_rd_byte,
  output logic                     o_busy,
  output logic                     o_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_WR_LEN  = 3'd2;
  localparam logic [2:0] S_CSUM_RD = 3'd3;
  localparam logic [2:0] S_FOLD    = 3'd4;
  localparam logic [2:0] S_CSUM_WR = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]               r_state;
  logic [4:0]               r_cnt;
  logic                     r_trig_d;
  logic [15:0]              r_ip_len;
  logic [15:0]              r_udp_len;
  logic [19:0]              r_sum;
  logic [7:0]               r_csum_lo;

  logic [ADDR_WIDTH-1:0]    w_diff;
  logic [15:0]              w_pay;
  logic [15:0]              w_ip_len;
  logic [15:0]              w_udp_len;
  logic [15:0]              w_ip_cur;
  logic [15:0]              w_udp_cur;
  logic [2:0]               w_wr_sel;
  logic [HDR_IDX_WIDTH-1:0] w_len_idx;
  logic [7:0]               w_len_byte;
  logic [4:0]               w_off;
  logic [19:0]              w_term;
  logic [15:0]              w_fold2;
  logic [15:0]              w_csum;

  assign w_diff    = i_next_data_st - i_data_st;
  assign w_pay     = 16'(w_diff) + 16'(LEN_ADJ);
  assign w_ip_len  = w_pay + 16'd28;
  assign w_udp_len = w_pay + 16'd8;

  // Length write 0 is issued from LEN, so it takes the lengths straight from the pointers.
  always_comb begin
    w_ip_cur   = (r_state == S_LEN) ? w_ip_len  : r_ip_len;
    w_udp_cur  = (r_state == S_LEN) ? w_udp_len : r_udp_len;
    w_wr_sel   = (r_state == S_LEN) ? 3'd0 : r_cnt[2:0] + 3'd1;
    w_len_idx  = HDR_IDX_WIDTH'(IP_HDR_BASE + 2);
    w_len_byte = w_ip_cur[15:8];
    case (w_wr_sel)
      3'd1: begin w_len_idx = HDR_IDX_WIDTH'(IP_HDR_BASE + 3);  w_len_byte = w_ip_cur[7:0];   end
      3'd2: begin w_len_idx = HDR_IDX_WIDTH'(UDP_HDR_BASE + 4); w_len_byte = w_udp_cur[15:8]; end
      3'd3: begin w_len_idx = HDR_IDX_WIDTH'(UDP_HDR_BASE + 5); w_len_byte = w_udp_cur[7:0];  end
      3'd4: begin w_len_idx = HDR_IDX_WIDTH'(UDP_HDR_BASE + 6); w_len_byte = 8'h00;           end
      3'd5: begin w_len_idx = HDR_IDX_WIDTH'(UDP_HDR_BASE + 7); w_len_byte = 8'h00;           end
      default: ;
    endcase
  end

  // Returned byte lags its read by one cycle; the checksum field itself counts as zero.
  always_comb begin
    w_off = r_cnt - 5'd1;
    if (w_off == 5'd10 || w_off == 5'd11) w_term = 20'd0;
    else if (!w_off[0])                   w_term = {4'b0, i_hdr_rd_byte, 8'h00};
    else                                  w_term = {12'b0, i_hdr_rd_byte};
  end

  assign w_fold2 = r_sum[15:0] + {15'b0, r_sum[16]};
  assign w_csum  = ~w_fold2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_trig_d    <= 1'b0;
      r_ip_len    <= 16'd0;
      r_udp_len   <= 16'd0;
      r_sum       <= 20'd0;
      r_csum_lo   <= 8'd0;
      o_hdr_idx   <= '0;
      o_hdr_byte  <= 8'd0;
      o_wr_hdr_en <= 1'b0;
      o_rd_hdr_en <= 1'b0;
      o_busy      <= 1'b0;
      o_ready     <= 1'b0;
    end else begin
      r_trig_d    <= i_trig;
      o_wr_hdr_en <= 1'b0;
      o_rd_hdr_en <= 1'b0;
      o_ready     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_trig && !r_trig_d) begin
            r_state <= S_LEN;
            o_busy  <= 1'b1;
          end
        end
        S_LEN: begin
          r_ip_len    <= w_ip_len;
          r_udp_len   <= w_udp_len;
          r_sum       <= 20'd0;
          r_cnt       <= 5'd0;
          o_wr_hdr_en <= 1'b1;
          o_hdr_idx   <= w_len_idx;
          o_hdr_byte  <= w_len_byte;
          r_state     <= S_WR_LEN;
        end
        S_WR_LEN: begin
          if (r_cnt == 5'd5) begin
            r_cnt <= 5'd0;
            if (CSUM_EN) begin
              o_rd_hdr_en <= 1'b1;
              o_hdr_idx   <= HDR_IDX_WIDTH'(IP_HDR_BASE);
              r_state     <= S_CSUM_RD;
            end else begin
              o_ready <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            o_wr_hdr_en <= 1'b1;
            o_hdr_idx   <= w_len_idx;
            o_hdr_byte  <= w_len_byte;
            r_cnt       <= r_cnt + 5'd1;
          end
        end
        S_CSUM_RD: begin
          if (r_cnt != 5'd0) r_sum <= r_sum + w_term;
          if (r_cnt < 5'd19) begin
            o_rd_hdr_en <= 1'b1;
            o_hdr_idx   <= HDR_IDX_WIDTH'(IP_HDR_BASE + int'(r_cnt) + 1);
          end
          if (r_cnt == 5'd20) begin
            r_cnt   <= 5'd0;
            r_state <= S_FOLD;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FOLD: begin
          if (r_cnt == 5'd0) begin
            r_sum <= {4'b0, r_sum[15:0]} + {16'b0, r_sum[19:16]};
            r_cnt <= 5'd1;
          end else begin
            o_wr_hdr_en <= 1'b1;
            o_hdr_idx   <= HDR_IDX_WIDTH'(IP_HDR_BASE + 10);
            o_hdr_byte  <= w_csum[15:8];
            r_csum_lo   <= w_csum[7:0];
            r_cnt       <= 5'd0;
            r_state     <= S_CSUM_WR;
          end
        end
        S_CSUM_WR: begin
          if (r_cnt == 5'd0) begin
            o_wr_hdr_en <= 1'b1;
            o_hdr_idx   <= HDR_IDX_WIDTH'(IP_HDR_BASE + 11);
            o_hdr_byte  <= r_csum_lo;
            r_cnt       <= 5'd1;
          end else begin
            o_ready <= 1'b1;
            r_cnt   <= 5'd0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/udp_ip_hdr_fill.md
# udp_ip_hdr_fill

Header finalisation engine for the transmit path. It runs once per rising edge of `i_trig`. It computes the datagram payload length from two packet-buffer pointers, with wrap-around handled. It then writes the IPv4 total length, the UDP length and a zero UDP checksum into the header buffer. Optionally it reads back the 20-byte IPv4 header and writes the IPv4 header checksum. It sits between the packet-buffer write logic and the header RAM, ahead of frame transmission.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: packet-buffer pointer width. Legal range 4..15.
- `LEN_ADJ`, 2: constant added to the pointer difference to form the payload length.
- `HDR_IDX_WIDTH`, 6: header-buffer address width.
- `IP_HDR_BASE`, 0: header-buffer index of IPv4 header byte 0.
- `UDP_HDR_BASE`, 20: header-buffer index of UDP header byte 0.
- `CSUM_EN`, 1: 1 = compute and write the IPv4 header checksum; 0 = skip it.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_trig`  in  1  start request; acts on its rising edge only.
- `i_data_st`  in  ADDR_WIDTH  payload start pointer.
- `i_next_data_st`  in  ADDR_WIDTH  next-packet start pointer.
- `o_hdr_idx`  out  HDR_IDX_WIDTH  header-buffer address, shared by reads and writes.
- `o_hdr_byte`  out  8  write data.
- `o_wr_hdr_en`  out  1  write strobe.
- `o_rd_hdr_en`  out  1  read strobe.
- `i_hdr_rd_byte`  in  8  read data; valid exactly 1 cycle after `o_rd_hdr_en`.
- `o_busy`  out  1  high from LEN through DONE.
- `o_ready`  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output and of `trig_d` is 0; state resets to IDLE.
- Edge detect: `trig_d` <= `i_trig` every cycle, in every state. Start condition is `i_trig & !trig_d`, evaluated in IDLE only. Edges arriving while busy are dropped, not queued.
- States:
  - IDLE → LEN on an edge.
  - LEN: capture both pointers and register the lengths; 1 cycle.
    - diff = (`i_next_data_st` − `i_data_st`) mod 2^ADDR_WIDTH.
    - pay = diff + LEN_ADJ, 16-bit.
    - udp_len = pay + 8.
    - ip_len = pay + 28.
  - WR_LEN: 6 writes, one per cycle, in this order:
    - (IP_HDR_BASE+2, ip_len[15:8])
    - (IP_HDR_BASE+3, ip_len[7:0])
    - (UDP_HDR_BASE+4, udp_len[15:8])
    - (UDP_HDR_BASE+5, udp_len[7:0])
    - (UDP_HDR_BASE+6, 0x00)
    - (UDP_HDR_BASE+7, 0x00)
  - After WR_LEN: go to CSUM_RD if CSUM_EN=1, else DONE.
  - CSUM_RD: 20 reads at IP_HDR_BASE+0..19.
    - Returned bytes form big-endian 16-bit words, summed into a 20-bit accumulator.
    - Bytes at offsets 10 and 11 are replaced by 0, whatever the buffer holds.
    - State lasts 21 cycles: 20 issue cycles plus 1 cycle for the last returned byte.
  - FOLD: 2 cycles.
    - Cycle 1: s = s[15:0] + s[19:16].
    - Cycle 2: s = s[15:0] + s[16]; csum = ~s[15:0].
  - CSUM_WR: write (IP_HDR_BASE+10, csum[15:8]), then (IP_HDR_BASE+11, csum[7:0]).
  - DONE: `o_ready` = 1 for 1 cycle → IDLE.
- `o_wr_hdr_en` and `o_rd_hdr_en` are never high in the same cycle. `o_hdr_idx` and `o_hdr_byte` hold their last value when both strobes are low.
- The header buffer makes a write visible to a read issued in the following cycle, so read-back sees the new lengths.
- Pointer wrap: `i_next_data_st` < `i_data_st` is legal; modulo subtraction applies. Equal pointers give pay = LEN_ADJ.
- Pointers are sampled only in LEN; changes at any other time are ignored.
- `i_rst` mid-operation: the next cycle is IDLE with all outputs 0 and no further writes. If `i_trig` is held high across reset release, an edge is detected in the first cycle after reset.

## Timing
Let T be the edge cycle: `i_trig`=1 and `trig_d`=0 in IDLE.
- T+1: LEN; `o_busy` rises.
- T+2..T+7: `o_wr_hdr_en`=1 (length and UDP-checksum writes).
- CSUM_EN=1:
  - T+8..T+27: `o_rd_hdr_en`=1.
  - T+9..T+28: read data returns.
  - T+29, T+30: fold.
  - T+31, T+32: checksum writes.
  - T+33: `o_ready`=1.
  - T+34: IDLE, `o_busy`=0; earliest cycle a new edge is accepted.
- CSUM_EN=0:
  - T+8: `o_ready`=1.
  - T+9: IDLE, `o_busy`=0.

## Test plan
- Basic lengths: st=100, next=164, CSUM_EN=0, LEN_ADJ=2 → writes 0x00/0x5E at idx 2/3, 0x00/0x4A at 24/25, 0x00/0x00 at 26/27; `o_ready` pulse at T+8.
- Wrap-around: ADDR_WIDTH=11, st=2040, next=8 → diff 16; ip_len 0x002E, udp_len 0x001A.
- Checksum: header preloaded with `45 00 00 00 00 00 40 00 40 11 FF FF C0 A8 00 01 C0 A8 00 C7`; st=0, next=85 → total length written 0x0073; checksum bytes 0xB8, 0x61 written at idx 10/11 at T+31/T+32; `o_ready` at T+33.
- Retrigger while busy: second rising edge at T+10 → ignored; exactly 8 writes total; a single `o_ready`.
- Reset at T+15: from T+16 all strobes and `o_ready` are 0, no writes occur, state is IDLE. With `i_trig` held high across release, a new run starts on the first cycle after release.
- Level `i_trig` held high for 100 cycles → exactly one run.
